// File: rtl/stage_memory_sb.sv
// stage_memory_sb: memory pipeline stage between execute and writeback.
// Carries the stage payload through, performs sized little-endian loads and
// stores over one request/response data-cache port, and posts stores into a
// SB_DEPTH-entry store buffer that drains in the background.
//
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   in_*                 instruction from execute (held stable while memory_busy)
//   memory_busy          combinational stall back to execute
//   out_*                registered stage outputs towards writeback
//   dc_req_* / dc_rsp_*  data-cache request/response port
//   sb_count             occupied store-buffer entries
module stage_memory_sb #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned SB_DEPTH  = 4,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [1:0]                in_op,
  input  logic [1:0]                in_size,
  input  logic                      in_signed,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_wdata,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  output logic                      memory_busy,
  output logic                      out_valid,
  output logic [1:0]                out_op,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [DATA_W-1:0]         out_result,
  output logic                      out_misalign,
  output logic                      dc_req_valid,
  output logic                      dc_req_write,
  output logic [ADDR_W-1:0]         dc_req_addr,
  output logic [DATA_W-1:0]         dc_req_wdata,
  output logic [DATA_W/8-1:0]       dc_req_be,
  input  logic                      dc_req_ready,
  input  logic                      dc_rsp_valid,
  input  logic [DATA_W-1:0]         dc_rsp_data,
  output logic [$clog2(SB_DEPTH):0] sb_count
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned OB   = $clog2(NB);
  localparam int unsigned PW   = $clog2(SB_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned WA_W = ADDR_W - OB;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  typedef struct packed {
    logic [WA_W-1:0]   waddr;
    logic [DATA_W-1:0] data;
    logic [NB-1:0]     be;
  } sb_entry_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_REQ  = 2'd1,
    S_LD_REQ  = 2'd2,
    S_LD_WAIT = 2'd3
  } state_t;

  // Byte enables for an access of 2^size bytes starting at lane.
  function automatic logic [NB-1:0] be_of(input logic [OB-1:0] lane, input logic [1:0] size);
    logic [NB-1:0] be;
    int unsigned   lo;
    int unsigned   n;
    lo = 32'(lane);
    n  = 32'd1 << size;
    be = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      be[b] = (b >= lo) && (b < lo + n);
    end
    return be;
  endfunction

  // Pull 2^size bytes starting at lane down to bit 0, then zero/sign-extend.
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                input logic [OB-1:0]     lane,
                                                input logic [1:0]        size,
                                                input logic              sgn);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    logic [7:0]        top;
    int unsigned       n;
    sh  = word >> {lane, 3'b000};
    n   = 32'd1 << size;
    top = 8'h00;
    res = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b == n - 1) top = sh[8*b +: 8];
    end
    for (int unsigned b = 0; b < NB; b++) begin
      res[8*b +: 8] = (b < n) ? sh[8*b +: 8] : {8{sgn & top[7]}};
    end
    return res;
  endfunction

  state_t               state_q, state_d;
  sb_entry_t            sb_q [SB_DEPTH];
  sb_entry_t            sb_d [SB_DEPTH];
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WA_W-1:0]      ld_waddr_q, ld_waddr_d;
  logic [OB-1:0]        ld_lane_q, ld_lane_d;
  logic [1:0]           ld_size_q, ld_size_d;
  logic                 ld_signed_q, ld_signed_d;
  logic                 out_valid_q, out_valid_d;
  logic [1:0]           out_op_q, out_op_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic [DATA_W-1:0]    out_result_q, out_result_d;
  logic                 out_misalign_q, out_misalign_d;

  logic [OB-1:0]        in_lane;
  logic [WA_W-1:0]      in_waddr;
  logic                 is_load, is_store, mem_op, misalign, mis_access;
  logic [NB-1:0]        in_be;
  logic [DATA_W-1:0]    in_wdata_sh;
  logic [DATA_W-1:0]    fwd_word;
  logic [NB-1:0]        fwd_cov;
  logic                 full_cov, any_cov;
  logic                 mem_retire, retire, push, pop, ld_go, ld_capture;
  logic [DATA_W-1:0]    ld_result;

  assign in_lane  = in_addr[OB-1:0];
  assign in_waddr = in_addr[ADDR_W-1:OB];

  // Decode of the presented instruction: op class, alignment, lanes.
  always_comb begin
    is_load  = in_valid && (in_op == OP_LOAD);
    is_store = in_valid && (in_op == OP_STORE);
    mem_op   = is_load || is_store;
    misalign = (32'(in_size) > OB);
    for (int unsigned b = 0; b < OB; b++) begin
      if ((b < 32'(in_size)) && in_addr[b]) misalign = 1'b1;
    end
    mis_access  = mem_op && misalign;
    in_be       = be_of(in_lane, in_size);
    in_wdata_sh = in_wdata << {in_lane, 3'b000};
  end

  // Store-buffer lookup: walk oldest to youngest so the youngest byte wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_word = '0;
    fwd_cov  = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((k < 32'(count_q)) && (sb_q[idx].waddr == in_waddr)) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (sb_q[idx].be[b]) begin
            fwd_word[8*b +: 8] = sb_q[idx].data[8*b +: 8];
            fwd_cov[b]         = 1'b1;
          end
        end
      end
    end
    full_cov = ((fwd_cov & in_be) == in_be);
    any_cov  = |(fwd_cov & in_be);
  end

  // Retire decision and stall; the full check uses the pre-pop occupancy.
  always_comb begin
    mem_retire = 1'b0;
    push       = 1'b0;
    ld_result  = '0;
    if (mis_access) begin
      mem_retire = 1'b1;
    end else if (is_store) begin
      if (count_q < CW'(SB_DEPTH)) begin
        mem_retire = 1'b1;
        push       = 1'b1;
      end
    end else if (is_load) begin
      if (state_q == S_LD_WAIT) begin
        if (dc_rsp_valid) begin
          mem_retire = 1'b1;
          ld_result  = extract(dc_rsp_data, ld_lane_q, ld_size_q, ld_signed_q);
        end
      end else if ((state_q != S_LD_REQ) && full_cov) begin
        mem_retire = 1'b1;
        ld_result  = extract(fwd_word, in_lane, in_size, in_signed);
      end
    end
    memory_busy = mem_op && !mem_retire;
    retire      = in_valid && !memory_busy;
    ld_go       = is_load && !misalign && !any_cov;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a waiting cache load beats a background drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ld_go)               state_d = S_LD_REQ;
        else if (count_q != '0)  state_d = S_WR_REQ;
      end
      S_WR_REQ:  if (dc_req_ready) state_d = S_IDLE;
      S_LD_REQ:  if (dc_req_ready) state_d = S_LD_WAIT;
      S_LD_WAIT: if (dc_rsp_valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request fields come only from flops, so they hold until ready.
  always_comb begin
    dc_req_valid = 1'b0;
    dc_req_write = 1'b0;
    dc_req_addr  = '0;
    dc_req_wdata = '0;
    dc_req_be    = '0;
    pop          = 1'b0;
    ld_capture   = 1'b0;
    case (state_q)
      S_IDLE: ld_capture = ld_go;
      S_WR_REQ: begin
        dc_req_valid = 1'b1;
        dc_req_write = 1'b1;
        dc_req_addr  = {sb_q[head_q].waddr, {OB{1'b0}}};
        dc_req_wdata = sb_q[head_q].data;
        dc_req_be    = sb_q[head_q].be;
        pop          = dc_req_ready;
      end
      S_LD_REQ: begin
        dc_req_valid = 1'b1;
        dc_req_addr  = {ld_waddr_q, {OB{1'b0}}};
        dc_req_be    = be_of(ld_lane_q, ld_size_q);
      end
      default: ;
    endcase
  end

  // Next values for the store buffer, load capture and output register.
  always_comb begin
    sb_d    = sb_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      sb_d[tail_q] = '{waddr: in_waddr, data: in_wdata_sh, be: in_be};
      tail_d       = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    ld_waddr_d  = ld_waddr_q;
    ld_lane_d   = ld_lane_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    if (ld_capture) begin
      ld_waddr_d  = in_waddr;
      ld_lane_d   = in_lane;
      ld_size_d   = in_size;
      ld_signed_d = in_signed;
    end

    out_valid_d    = retire;
    out_op_d       = retire ? in_op : 2'd0;
    out_payload_d  = retire ? in_payload : '0;
    out_result_d   = retire ? ld_result : '0;
    out_misalign_d = retire && mis_access;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      ld_waddr_q     <= '0;
      ld_lane_q      <= '0;
      ld_size_q      <= '0;
      ld_signed_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_op_q       <= '0;
      out_payload_q  <= '0;
      out_result_q   <= '0;
      out_misalign_q <= 1'b0;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= sb_d[i];
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      ld_waddr_q     <= ld_waddr_d;
      ld_lane_q      <= ld_lane_d;
      ld_size_q      <= ld_size_d;
      ld_signed_q    <= ld_signed_d;
      out_valid_q    <= out_valid_d;
      out_op_q       <= out_op_d;
      out_payload_q  <= out_payload_d;
      out_result_q   <= out_result_d;
      out_misalign_q <= out_misalign_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_op       = out_op_q;
  assign out_payload  = out_payload_q;
  assign out_result   = out_result_q;
  assign out_misalign = out_misalign_q;
  assign sb_count     = count_q;

endmodule

// File: tb/tb_stage_memory_sb.sv
// Directed bench for stage_memory_sb: a vector table for single-cycle
// retirements plus hand-written multi-cycle cache and drain sequences.
module tb_stage_memory_sb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = '0;
  logic [1:0]  in_size = '0;
  logic        in_signed = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [63:0] in_payload = '0;
  logic        memory_busy;
  logic        out_valid;
  logic [1:0]  out_op;
  logic [63:0] out_payload;
  logic [31:0] out_result;
  logic        out_misalign;
  logic        dc_req_valid;
  logic        dc_req_write;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_wdata;
  logic [3:0]  dc_req_be;
  logic        dc_req_ready = 1'b0;
  logic        dc_rsp_valid = 1'b0;
  logic [31:0] dc_rsp_data = '0;
  logic [2:0]  sb_count;

  always #5 clock = ~clock;

  stage_memory_sb dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_op(in_op), .in_size(in_size), .in_signed(in_signed),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_payload(in_payload),
    .memory_busy(memory_busy),
    .out_valid(out_valid), .out_op(out_op), .out_payload(out_payload),
    .out_result(out_result), .out_misalign(out_misalign),
    .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be), .dc_req_ready(dc_req_ready),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .sb_count(sb_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [63:0] payload);
    in_valid   = v;
    in_op      = op;
    in_size    = size;
    in_signed  = sgn;
    in_addr    = addr;
    in_wdata   = wdata;
    in_payload = payload;
  endtask

  task automatic do_reset();
    set_in(1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 64'h0);
    dc_req_ready = 1'b0;
    dc_rsp_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] payload;
    logic [31:0] exp_result;
    logic        exp_mis;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs [15];

  logic table_phase = 1'b0;
  logic saw_read    = 1'b0;
  always @(negedge clock) begin
    if (table_phase && dc_req_valid && !dc_req_write) saw_read <= 1'b1;
  end

  logic [31:0] exp_hs_addr [5];
  logic [31:0] exp_hs_data [5];
  logic [3:0]  exp_hs_be   [5];

  initial begin
    logic busy_now, retired, done, first_busy, wr_seen, rd_seen, rd_before_wr, rsp_pending, hs_rd;
    int   hs_n;

    // Dispatch with dc_req_ready low, so stores stay buffered throughout.
    vecs[0]  = '{1'b1, 2'd0, 2'd0, 1'b0, 32'h000, 32'h0,        64'h1111, 32'h00000000, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 2'd1, 2'd2, 1'b0, 32'h100, 32'h0,        64'h2222, 32'h00000000, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, 2'd2, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 64'h3333, 32'h00000000, 1'b0, 3'd1};
    vecs[3]  = '{1'b1, 2'd1, 2'd0, 1'b1, 32'h101, 32'h0,        64'h4444, 32'hFFFFFFBE, 1'b0, 3'd1};
    vecs[4]  = '{1'b1, 2'd1, 2'd0, 1'b0, 32'h101, 32'h0,        64'h5555, 32'h000000BE, 1'b0, 3'd1};
    vecs[5]  = '{1'b1, 2'd1, 2'd1, 1'b0, 32'h102, 32'h0,        64'h6666, 32'h0000DEAD, 1'b0, 3'd1};
    vecs[6]  = '{1'b1, 2'd1, 2'd1, 1'b1, 32'h102, 32'h0,        64'h7777, 32'hFFFFDEAD, 1'b0, 3'd1};
    vecs[7]  = '{1'b1, 2'd1, 2'd2, 1'b0, 32'h100, 32'h0,        64'h8888, 32'hDEADBEEF, 1'b0, 3'd1};
    vecs[8]  = '{1'b1, 2'd1, 2'd2, 1'b0, 32'h102, 32'h0,        64'h9999, 32'h00000000, 1'b1, 3'd1};
    vecs[9]  = '{1'b1, 2'd2, 2'd1, 1'b0, 32'h101, 32'hFFFF,     64'hAAAA, 32'h00000000, 1'b1, 3'd1};
    vecs[10] = '{1'b1, 2'd2, 2'd0, 1'b0, 32'h103, 32'h55,       64'hBBBB, 32'h00000000, 1'b0, 3'd2};
    vecs[11] = '{1'b1, 2'd1, 2'd2, 1'b0, 32'h100, 32'h0,        64'hCCCC, 32'h55ADBEEF, 1'b0, 3'd2};
    vecs[12] = '{1'b1, 2'd3, 2'd0, 1'b0, 32'h100, 32'h0,        64'hDDDD, 32'h00000000, 1'b0, 3'd2};
    vecs[13] = '{1'b1, 2'd1, 2'd3, 1'b0, 32'h000, 32'h0,        64'hEEEE, 32'h00000000, 1'b1, 3'd2};
    vecs[14] = '{1'b1, 2'd1, 2'd0, 1'b1, 32'h103, 32'h0,        64'hF0F0, 32'h00000055, 1'b0, 3'd2};

    exp_hs_addr[0] = 32'h00; exp_hs_data[0] = 32'h11000000; exp_hs_be[0] = 4'b1000;
    exp_hs_addr[1] = 32'h10; exp_hs_data[1] = 32'hCAFEF00D; exp_hs_be[1] = 4'b1111;
    exp_hs_addr[2] = 32'h20; exp_hs_data[2] = 32'hBBBB0000; exp_hs_be[2] = 4'b1100;
    exp_hs_addr[3] = 32'h04; exp_hs_data[3] = 32'h0000CC00; exp_hs_be[3] = 4'b0010;
    exp_hs_addr[4] = 32'h40; exp_hs_data[4] = 32'h76543210; exp_hs_be[4] = 4'b1111;

    // Reset state.
    do_reset();
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_payload", out_payload, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_misalign", out_misalign, 0);
    chk("rst_dc_req_valid", dc_req_valid, 0);
    chk("rst_sb_count", sb_count, 0);
    chk("rst_busy", memory_busy, 0);
    tick();

    // Vector table.
    table_phase = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].valid, vecs[i].op, vecs[i].size, vecs[i].sgn, vecs[i].addr,
             vecs[i].wdata, vecs[i].payload);
      @(negedge clock);
      chk($sformatf("vec%0d_busy", i), memory_busy, 0);
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].valid);
      chk($sformatf("vec%0d_op", i), out_op, vecs[i].valid ? vecs[i].op : 2'd0);
      chk($sformatf("vec%0d_payload", i), out_payload, vecs[i].valid ? vecs[i].payload : 64'h0);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp_result);
      chk($sformatf("vec%0d_misalign", i), out_misalign, vecs[i].exp_mis);
      chk($sformatf("vec%0d_sb_count", i), sb_count, vecs[i].exp_count);
    end
    in_valid = 1'b0;
    tick();
    table_phase = 1'b0;
    chk("fwd_no_dc_read", saw_read, 0);

    // Cache half load with a slow request handshake.
    do_reset();
    set_in(1'b1, 2'd1, 2'd1, 1'b0, 32'h200, 32'h0, 64'h5151);
    @(negedge clock);
    chk("ld_accept_busy", memory_busy, 1);
    chk("ld_accept_no_req", dc_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clock);
      chk($sformatf("ld_hold%0d_valid", i), dc_req_valid, 1);
      chk($sformatf("ld_hold%0d_write", i), dc_req_write, 0);
      chk($sformatf("ld_hold%0d_addr", i), dc_req_addr, 32'h200);
      chk($sformatf("ld_hold%0d_be", i), dc_req_be, 4'b0011);
      chk($sformatf("ld_hold%0d_busy", i), memory_busy, 1);
    end
    tick();
    dc_req_ready = 1'b1;
    @(negedge clock);
    chk("ld_hs_valid", dc_req_valid, 1);
    tick();
    dc_req_ready = 1'b0;
    @(negedge clock);
    chk("ld_wait_busy", memory_busy, 1);
    chk("ld_wait_no_req", dc_req_valid, 0);
    tick();
    dc_rsp_valid = 1'b1;
    dc_rsp_data  = 32'h00008001;
    @(negedge clock);
    chk("ld_rsp_busy", memory_busy, 0);
    tick();
    dc_rsp_valid = 1'b0;
    in_valid     = 1'b0;
    chk("ld_out_valid", out_valid, 1);
    chk("ld_out_result", out_result, 32'h00008001);
    chk("ld_out_payload", out_payload, 64'h5151);
    chk("ld_out_misalign", out_misalign, 0);
    tick();
    chk("ld_bubble_after", out_valid, 0);

    // Fill the store buffer while the cache refuses, then drain in order.
    set_in(1'b1, 2'd2, 2'd0, 1'b0, 32'h03, 32'h11, 64'h1);
    @(negedge clock); chk("st1_busy", memory_busy, 0); tick();
    set_in(1'b1, 2'd2, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 64'h2);
    @(negedge clock); chk("st2_busy", memory_busy, 0); tick();
    set_in(1'b1, 2'd2, 2'd1, 1'b0, 32'h22, 32'hBBBB, 64'h3);
    @(negedge clock); chk("st3_busy", memory_busy, 0); tick();
    set_in(1'b1, 2'd2, 2'd0, 1'b0, 32'h05, 32'hCC, 64'h4);
    @(negedge clock); chk("st4_busy", memory_busy, 0); tick();
    set_in(1'b1, 2'd2, 2'd2, 1'b0, 32'h40, 32'h76543210, 64'h5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk($sformatf("st5_full%0d_busy", i), memory_busy, 1);
      chk($sformatf("st5_full%0d_count", i), sb_count, 4);
      tick();
      chk($sformatf("st5_full%0d_bubble", i), out_valid, 0);
    end
    dc_req_ready = 1'b1;
    hs_n    = 0;
    retired = 1'b0;
    for (int c = 0; c < 40 && hs_n < 5; c++) begin
      @(negedge clock);
      busy_now = memory_busy;
      if (dc_req_valid && dc_req_ready) begin
        chk($sformatf("drain%0d_write", hs_n), dc_req_write, 1);
        chk($sformatf("drain%0d_addr", hs_n), dc_req_addr, exp_hs_addr[hs_n]);
        chk($sformatf("drain%0d_data", hs_n), dc_req_wdata, exp_hs_data[hs_n]);
        chk($sformatf("drain%0d_be", hs_n), dc_req_be, exp_hs_be[hs_n]);
        hs_n++;
      end
      tick();
      if (in_valid && !busy_now) begin
        chk("st5_retire_valid", out_valid, 1);
        chk("st5_retire_op", out_op, 2);
        chk("st5_retire_payload", out_payload, 64'h5);
        in_valid = 1'b0;
        retired  = 1'b1;
      end
    end
    chk("drain_count", hs_n, 5);
    chk("st5_retired", retired, 1);
    tick();
    @(negedge clock);
    chk("drain_sb_empty", sb_count, 0);
    chk("drain_idle", dc_req_valid, 0);
    tick();

    // Partial overlap: load waits for the byte write, then reads the cache.
    set_in(1'b1, 2'd2, 2'd0, 1'b0, 32'h300, 32'hAA, 64'h6);
    @(negedge clock); chk("po_store_busy", memory_busy, 0); tick();
    set_in(1'b1, 2'd1, 2'd2, 1'b0, 32'h300, 32'h0, 64'h7);
    rsp_pending  = 1'b0;
    wr_seen      = 1'b0;
    rd_seen      = 1'b0;
    rd_before_wr = 1'b0;
    done         = 1'b0;
    first_busy   = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      dc_rsp_valid = rsp_pending;
      dc_rsp_data  = rsp_pending ? 32'h12345678 : 32'h0;
      @(negedge clock);
      busy_now = memory_busy;
      if (c == 0) first_busy = busy_now;
      hs_rd = dc_req_valid && dc_req_ready && !dc_req_write;
      if (dc_req_valid && dc_req_ready && dc_req_write && !wr_seen) begin
        wr_seen = 1'b1;
        chk("po_wr_addr", dc_req_addr, 32'h300);
        chk("po_wr_be", dc_req_be, 4'b0001);
        chk("po_wr_data", dc_req_wdata, 32'h000000AA);
      end
      if (hs_rd && !rd_seen) begin
        rd_seen = 1'b1;
        if (!wr_seen) rd_before_wr = 1'b1;
        chk("po_rd_addr", dc_req_addr, 32'h300);
        chk("po_rd_be", dc_req_be, 4'b1111);
      end
      tick();
      if (!busy_now) begin
        done = 1'b1;
        chk("po_out_valid", out_valid, 1);
        chk("po_out_result", out_result, 32'h12345678);
      end
      rsp_pending = hs_rd;
    end
    in_valid     = 1'b0;
    dc_rsp_valid = 1'b0;
    chk("po_done", done, 1);
    chk("po_first_busy", first_busy, 1);
    chk("po_wr_seen", wr_seen, 1);
    chk("po_rd_seen", rd_seen, 1);
    chk("po_rd_after_wr", rd_before_wr, 0);
    tick();

    // Reset while a read is outstanding; the late response must be dropped.
    set_in(1'b1, 2'd1, 2'd2, 1'b0, 32'h400, 32'h0, 64'h8);
    dc_req_ready = 1'b1;
    tick();
    tick();
    @(negedge clock);
    chk("rw_wait_busy", memory_busy, 1);
    chk("rw_wait_no_req", dc_req_valid, 0);
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset        = 1'b0;
    dc_rsp_valid = 1'b1;
    dc_rsp_data  = 32'hFFFFFFFF;
    tick();
    dc_rsp_valid = 1'b0;
    chk("rw_no_out_valid", out_valid, 0);
    chk("rw_no_out_result", out_result, 0);
    @(negedge clock);
    chk("rw_no_req", dc_req_valid, 0);
    chk("rw_sb_count", sb_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_memory_sb.md
# stage_memory_sb

Parametrised memory pipeline stage that sits between the execute stage and the writeback register. It carries the stage payload through and performs sized, little-endian loads and stores through a single request/response data-cache port. Stores are posted into a SB_DEPTH-entry store buffer and drained in the background, so they retire without waiting for the cache. Loads forward from the buffer when it fully covers them, drain it when it partially overlaps them, and otherwise go to the cache. Any cycle in which the input instruction cannot retire raises memory_busy and inserts a bubble.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, power of 2; NB = DATA_W/8, OB = log2(NB)
- ADDR_W, 32, byte-address width
- SB_DEPTH, 4, store-buffer entries; power of 2, ≥2
- PAYLOAD_W, 64, opaque stage fields passed through unchanged
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  execute stage presents an instruction
- in_op  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none)
- in_size  in  2  access = 2^in_size bytes
- in_signed  in  1  sign-extend load result
- in_addr  in  ADDR_W  byte address
- in_wdata  in  DATA_W  store data, right-aligned
- in_payload  in  PAYLOAD_W  stage fields
- memory_busy  out  1  stall; execute holds all in_* stable
- out_valid  out  1  registered stage-valid
- out_op  out  2  registered op
- out_payload  out  PAYLOAD_W  registered payload
- out_result  out  DATA_W  load result; 0 for everything else
- out_misalign  out  1  retired access was misaligned
- dc_req_valid  out  1  cache request
- dc_req_write  out  1  1 write, 0 read
- dc_req_addr  out  ADDR_W  word-aligned (low OB bits 0)
- dc_req_wdata  out  DATA_W  lane-positioned write data
- dc_req_be  out  NB  byte enables
- dc_req_ready  in  1  cache accepts the request this cycle
- dc_rsp_valid  in  1  read data valid; writes get no response
- dc_rsp_data  in  DATA_W  read word
- sb_count  out  log2(SB_DEPTH)+1  occupied store-buffer entries

## Operation
- An access is misaligned when in_addr mod 2^in_size ≠ 0 or when in_size > OB. A misaligned access:
  - retires in the same cycle;
  - sets out_misalign = 1 and out_result = 0;
  - makes no store-buffer or cache access.
- Lane and byte enables: lane = addr[OB-1:0]; be = ((1 << 2^size) − 1) << lane. Write data is shifted left by 8·lane.
- Store retires in the acceptance cycle iff sb_count < SB_DEPTH; it enqueues {word addr, shifted data, be} at the tail. If the buffer is full, memory_busy = 1. The full check uses sb_count before any same-cycle pop.
- Load store-buffer check compares the load's word address against all valid entries. Byte-wise merge, youngest entry wins per byte.
  - Every requested byte covered: the load retires in the acceptance cycle with the forwarded data and no cache access.
  - Some but not all requested bytes covered: memory_busy = 1 and the load is re-evaluated each cycle while the buffer drains.
  - No overlap: the load may bypass older stores to the cache.
- Load extraction: take bytes [lane, lane+2^size), shift right to bit 0, then zero- or sign-extend to DATA_W.
- FSM:
  - IDLE:
    - A valid, aligned, non-overlapping load captures its address and size, then → LD_REQ.
    - Otherwise, if sb_count > 0 → WR_REQ.
    - Loads take priority over draining.
  - WR_REQ: drives the head entry with dc_req_write = 1. On dc_req_ready: pop the head → IDLE.
  - LD_REQ: drives the captured read. On dc_req_ready → LD_WAIT.
  - LD_WAIT: on dc_rsp_valid the load retires this cycle → IDLE. dc_rsp_valid in any other state is ignored.
- Request rule: once dc_req_valid is asserted, all dc_req_* fields are held constant until dc_req_ready. At most one request or read is outstanding at a time.
- memory_busy (combinational) = in_valid && op ∈ {load, store} && the instruction is not retiring this cycle. Non-memory ops never stall.
- Output register, each cycle:
  - Retiring instruction: out_* ← in_*, plus out_result and out_misalign.
  - Busy cycle or !in_valid: out_valid, out_op, out_payload, out_result and out_misalign all ← 0 (bubble).
- Reset:
  - FSM → IDLE; store buffer emptied (pending stores are discarded); all outputs 0.
  - A cache response arriving after reset is ignored.

## Timing
- Non-memory op, aligned store with space, fully forwarded load, or misaligned access: accepted in cycle T, out_valid at T+1.
- Cache load accepted at T:
  - dc_req_valid from T+1 until ready;
  - busy through the dc_rsp_valid cycle R;
  - out_valid at R+1.
- Store buffer drain: at most one entry per dc_req_ready handshake. A freshly enqueued store is drainable no earlier than the following cycle.
- A simultaneous enqueue and pop leaves sb_count unchanged. Head and tail pointers wrap modulo SB_DEPTH.

## Test plan
- Reset → all outputs 0, sb_count = 0, dc_req_valid = 0. Assert reset during LD_WAIT, then pulse dc_rsp_valid → no out_valid.
- Store word 0xDEADBEEF @0x100, then signed byte load @0x101 → no dc read; out_result = 0xFFFFFFBE one cycle after acceptance.
- Unsigned half load @0x200, dc_req_ready held low 3 cycles, rsp 0x00008001 → req held stable; busy until the response cycle; out_result = 0x00008001.
- Five stores with dc_req_ready = 0 → 5th store busy and sb_count = 4. Release ready → writes are issued in program order with the correct be (e.g. byte @0x3 → be = 4'b1000), then the 5th store retires.
- Store byte 0xAA @0x300, then word load @0x300 → load stalls until the byte write is drained, then a dc read is issued; result = cache data.
- Word load @0x102 → out_misalign = 1, out_result = 0, no dc request, retires in 1 cycle.
